// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  // Controller states; encodings are fixed so they can be observed in waveforms/debug.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Iteration counter width: enough bits to count 0..width-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/Full_Adder.sv
// One-bit full adder cell used to build ripple-carry arithmetic.
module Full_Adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_in_i,
  output logic sum_o,
  output logic c_out_o
);

  assign sum_o   = a_i ^ b_i ^ c_in_i;
  assign c_out_o = (a_i & b_i) | (a_i & c_in_i) | (b_i & c_in_i);

endmodule

// File: rtl/ripple_sub.sv
// N-bit subtractor a_i - b_i as a chain of full adders (b inverted, carry-in 1).
// carry_o is the not-borrow flag: 1 when a_i >= b_i.
module ripple_sub #(
  parameter int unsigned N = 33
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         carry_o
);

  logic [N:0] carry;

  assign carry[0] = 1'b1;

  // Ripple chain of full adders adding the one's complement of b_i.
  for (genvar i = 0; i < int'(N); i++) begin : g_fa
    Full_Adder u_fa (
      .a_i     (a_i[i]),
      .b_i     (~b_i[i]),
      .c_in_i  (carry[i]),
      .sum_o   (diff_o[i]),
      .c_out_o (carry[i+1])
    );
  end

  assign carry_o = carry[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned multi-cycle restoring divider: one quotient bit per clock, start/done handshake.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned RW    = WIDTH + 1;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [RW-1:0]    shifted_r;
  logic [RW-1:0]    trial_diff;
  logic             no_borrow;

  // Shift the next dividend bit into the partial remainder and trial-subtract the divisor.
  assign shifted_r = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  ripple_sub #(.N(RW)) u_sub (
    .a_i     (shifted_r),
    .b_i     ({1'b0, d_q}),
    .diff_o  (trial_diff),
    .carry_o (no_borrow)
  );

  // Next-state, datapath and output-register update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (divisor != '0) begin
            state_d = CALC;
            q_d     = dividend;
            r_d     = '0;
            d_d     = divisor;
            cnt_d   = '0;
          end else begin
            // Divide by zero resolves immediately with a flagged, well-defined result.
            state_d = DONE;
            done_d  = 1'b1;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
        end
      end
      CALC: begin
        if (no_borrow) begin
          r_d = trial_diff;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = shifted_r;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          quot_d  = q_d;
          rem_d   = r_d[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8) with a result scoreboard.
module tb_seq_restoring_divider;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("quotient", 32'(quotient), 32'(mon_e.q));
        check_eq("remainder", 32'(remainder), 32'(mon_e.r));
        check_eq("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
        check_eq("latency", 32'(cyc), 32'(mon_e.cyc));
        check_eq("busy_with_done", 32'(busy), 32'd0);
      end
    end
  end

  // Reference model; called at a negedge just before the accepting posedge.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int now);
    exp_t e;
    e.dbz = (b == '0);
    e.q   = e.dbz ? {W{1'b1}} : W'(a / b);
    e.r   = e.dbz ? a : W'(a % b);
    e.cyc = now + 1 + (e.dbz ? 0 : int'(W));
    return e;
  endfunction

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    sb.push_back(model(a, b, cyc));
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'(b != '0));
    wait_drain();
  endtask

  initial begin
    int n;
    logic [W-1:0] ra, rb;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_quotient", 32'(quotient), 32'd0);
    check_eq("rst_remainder", 32'(remainder), 32'd0);
    check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    // Basic divisions and boundaries
    do_op(8'd100, 8'd7);
    do_op(8'd5, 8'd9);
    do_op(8'd255, 8'd1);

    // Divide by zero: single-cycle, busy stays low
    do_op(8'd77, 8'd0);
    @(negedge clk);
    check_eq("dbz_busy_low", 32'(busy), 32'd0);

    // Start while busy is ignored
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    sb.push_back(model(8'd200, 8'd3, cyc));
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 8'd2;
    @(negedge clk); start = 1'b0;
    wait_drain();

    // Reset mid-calculation aborts without a done pulse
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_quotient", 32'(quotient), 32'd0);
    check_eq("abort_remainder", 32'(remainder), 32'd0);
    check_eq("abort_dbz", 32'(div_by_zero), 32'd0);
    repeat (12) @(negedge clk);
    do_op(8'd50, 8'd6);

    // Back-to-back: new start accepted in the DONE cycle
    @(negedge clk);
    start = 1'b1; dividend = 8'd40; divisor = 8'd5;
    sb.push_back(model(8'd40, 8'd5, cyc));
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("b2b_first_done", 32'(done), 32'd1);
    start = 1'b1; dividend = 8'd17; divisor = 8'd4;
    sb.push_back(model(8'd17, 8'd4, cyc));
    @(negedge clk); start = 1'b0;
    check_eq("b2b_busy", 32'(busy), 32'd1);
    check_eq("b2b_hold_quotient", 32'(quotient), 32'd8);
    check_eq("b2b_hold_remainder", 32'(remainder), 32'd0);
    wait_drain();

    // Random sweep against the reference model, biased toward corner divisors
    for (int i = 0; i < 2000; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1:       rb = 8'd1;
        2:       rb = 8'hFF;
        3:       rb = ra;
        default: rb = W'($urandom);
      endcase
      do_op(ra, rb);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
